ek_sat_mc: RTL and testbench
============================

Name: ek_sat_mc

Overview:
- Parametrised, pipelined, multi-channel error stage for the fixed-point control loop.
- Per accepted sample: computes e[k] = ref - yk at full precision, saturates it to a configurable signed range, and keeps a per-channel history of e[k-1] and e[k-2].
- Outputs e[k], e[k-1], e[k-2] and de = e[k] - e[k-1] for velocity-form PID, plus sticky per-channel saturation flags and a saturating event counter.
- Replaces the single-channel combinational error block ahead of the controller datapath.

Parameters:
- N, 18: word width of ref, yk and all error outputs (signed two's complement, same Q format as the rest of the loop).
- LIM_W, 9: saturation range is signed LIM_W bits, i.e. [-(2^(LIM_W-1)), 2^(LIM_W-1)-1] LSBs. Legal range 2..N-1.
- CH, 4: number of time-multiplexed channels, 1..16.
- CH_W, 2: width of channel index, ceil(log2(CH)) with minimum 1.
- CNT_W, 16: width of the saturation event counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  sample strobe; a sample is accepted on every cycle it is high (no backpressure)
- in_ch  in  CH_W  channel index of the sample
- ref  in  N  signed reference
- yk  in  N  signed plant output
- hist_clr  in  1  one-cycle request to zero the history of all channels
- sat_clr  in  1  one-cycle request to clear sat_flags and sat_cnt
- out_valid  out  1  result strobe
- out_ch  out  CH_W  channel of the result
- ek  out  N  saturated e[k]
- ek1  out  N  e[k-1] for the channel (value before this sample)
- ek2  out  N  e[k-2] for the channel
- dek  out  N  ek - ek1, exact
- sat_now  out  1  high with out_valid when this e[k] was clamped
- sat_flags  out  CH  sticky per-channel clamp flags
- sat_cnt  out  CNT_W  count of clamp events; holds at all-ones

Behaviour:
- Reset is synchronous and active-high. While it is sampled high, all of the following are 0 on the next edge: pipeline valids, out_valid, out_ch, ek, ek1, ek2, dek, sat_now, sat_flags, sat_cnt and all channel history.
- Reset mid-stream discards any in-flight samples; no out_valid is produced for them.
- Stage 1 (register):
  - Captures diff = sign-extended ref minus sign-extended yk in N+1 bits. The subtraction cannot wrap.
  - Captures in_ch and a valid bit.
  - A sample with in_ch >= CH is dropped: its stage-1 valid bit is cleared.
- Stage 2 (register):
  - Clamp: diff > 2^(LIM_W-1)-1 gives MAX, and diff < -(2^(LIM_W-1)) gives MIN; either sets sat_now. Otherwise diff passes unchanged. The result is sign-extended to N bits as ek.
  - Reads the channel's history as ek1 and ek2, and computes dek = ek - ek1. This always fits in N because LIM_W <= N-1.
  - Writes the history as new e[k-1] = ek and new e[k-2] = old e[k-1].
  - Asserts out_valid for one cycle.
- Latency: exactly 2 cycles from in_valid to out_valid. Throughput is one sample per cycle. Outputs hold their last values when out_valid is low.
- History is read and written in the same stage, so back-to-back samples on the same channel see the fully updated history. There is no hazard and no bubble.
- hist_clr:
  - All histories are 0 after the edge.
  - A stage-2 sample in that same cycle outputs using the pre-clear history, and its history write is discarded.
- sat_clr:
  - sat_flags and sat_cnt are 0 after the edge.
  - If a clamp event occurs in the same cycle, the event wins: that channel's flag is 1 and sat_cnt is 1 after the edge.
- sat_cnt increments by 1 per clamp event and saturates at 2^CNT_W-1; it never wraps.
- The saturation limits are applied to the mathematically exact difference. Full-scale inputs of opposite sign clamp correctly and never alias.

Test Plan (N=18, LIM_W=9, CH=4):
- reset, then ch0 ref=100, yk=30 -> two cycles later out_valid=1, ek=70, ek1=0, ek2=0, dek=70, sat_now=0.
- ch1 ref=1000, yk=0, then ch1 ref=-1000, yk=0 -> ek=255 with sat_flags=0010 and sat_cnt=1; then ek=-256, ek1=255, dek=-511, sat_cnt=2.
- ref=131071, yk=-131072 (exact 262143) -> ek=255, sat_now=1 (no wrap to a negative value).
- interleaved ch0,ch2,ch0,ch0 with errors 5,7,9,11 on consecutive cycles -> final ch0 result has ek=11, ek1=9, ek2=5; ch2 result has ek1=0.
- hist_clr in the cycle a ch3 sample is in stage 2 -> that result uses the old history, and the next ch3 result has ek1=0 and ek2=0.
- sat_clr coincident with a clamp on ch2 -> sat_flags=0100 and sat_cnt=1.
- in_ch=3 with CH=3 -> no out_valid.
- reset asserted while two samples are in flight -> no out_valid for either, and all outputs are 0.

Source files
------------

// File: rtl/ek_sat_mc.sv
`default_nettype none
// ============================================================================
// Module   : ek_sat_mc
// Function : Two-stage, multi-channel error stage for the control loop.
//            Computes e[k] = ref - yk exactly, clamps it to a signed LIM_W-bit
//            range, and keeps per-channel e[k-1]/e[k-2] history. Also keeps
//            sticky clamp flags and a saturating clamp-event counter.
//            The reference input is named refk because ref is a keyword.
// Revision : 1.0  initial release
// ============================================================================
module ek_sat_mc #(
  parameter int N     = 18,
  parameter int LIM_W = 9,
  parameter int CH    = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [CH_W-1:0]      in_ch,
  input  logic signed [N-1:0]  refk,
  input  logic signed [N-1:0]  yk,
  input  logic                 hist_clr,
  input  logic                 sat_clr,
  output logic                 out_valid,
  output logic [CH_W-1:0]      out_ch,
  output logic signed [N-1:0]  ek,
  output logic signed [N-1:0]  ek1,
  output logic signed [N-1:0]  ek2,
  output logic signed [N-1:0]  dek,
  output logic                 sat_now,
  output logic [CH-1:0]        sat_flags,
  output logic [CNT_W-1:0]     sat_cnt
);

  // Clamp limits expressed in the N+1-bit exact-difference domain.
  localparam logic signed [N:0] c_max =
    {{(N - LIM_W + 2){1'b0}}, {(LIM_W - 1){1'b1}}};
  localparam logic signed [N:0] c_min =
    {{(N - LIM_W + 2){1'b1}}, {(LIM_W - 1){1'b0}}};
  localparam logic [CH_W:0]    c_ch_lim  = (CH_W + 1)'(CH);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic                 r_s1_valid;
  logic [CH_W-1:0]      r_s1_ch;
  logic signed [N:0]    r_s1_diff;
  logic signed [N-1:0]  r_hist1 [CH];
  logic signed [N-1:0]  r_hist2 [CH];

  logic signed [N:0]    w_diff_in;
  logic                 w_hi;
  logic                 w_lo;
  logic                 w_clamp;
  logic signed [N-1:0]  w_ek;
  logic signed [N-1:0]  w_ek1;
  logic signed [N-1:0]  w_ek2;
  logic signed [N-1:0]  w_dek;
  logic [CH-1:0]        w_onehot;

  // Exact difference: one extra bit so full-scale opposite-sign inputs never wrap.
  assign w_diff_in = {refk[N-1], refk} - {yk[N-1], yk};

  // Stage 1: capture exact difference, channel and validity (out-of-range channels dropped).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_diff  <= '0;
    end else begin
      r_s1_valid <= in_valid && ({1'b0, in_ch} < c_ch_lim);
      r_s1_ch    <= in_ch;
      r_s1_diff  <= w_diff_in;
    end
  end

  // Stage-2 combinational: clamp, history lookup and velocity-form delta.
  always_comb begin
    w_hi     = r_s1_diff > c_max;
    w_lo     = r_s1_diff < c_min;
    w_clamp  = r_s1_valid && (w_hi || w_lo);
    w_ek     = r_s1_diff[N-1:0];
    if (w_hi) begin
      w_ek = c_max[N-1:0];
    end else if (w_lo) begin
      w_ek = c_min[N-1:0];
    end
    w_ek1    = r_hist1[r_s1_ch];
    w_ek2    = r_hist2[r_s1_ch];
    w_dek    = w_ek - w_ek1;
    w_onehot = CH'(1) << r_s1_ch;
  end

  // Stage 2 output register: results update only on a valid sample and hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      ek        <= '0;
      ek1       <= '0;
      ek2       <= '0;
      dek       <= '0;
      sat_now   <= 1'b0;
    end else begin
      out_valid <= r_s1_valid;
      sat_now   <= w_clamp;
      if (r_s1_valid) begin
        out_ch <= r_s1_ch;
        ek     <= w_ek;
        ek1    <= w_ek1;
        ek2    <= w_ek2;
        dek    <= w_dek;
      end
    end
  end

  // History shift per channel; a clear wins over the coincident sample's write.
  always_ff @(posedge clk) begin
    if (reset || hist_clr) begin
      for (int i = 0; i < CH; i++) begin
        r_hist1[i] <= '0;
        r_hist2[i] <= '0;
      end
    end else if (r_s1_valid) begin
      r_hist1[r_s1_ch] <= w_ek;
      r_hist2[r_s1_ch] <= w_ek1;
    end
  end

  // Sticky flags and saturating event counter; a coincident clamp beats sat_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flags <= '0;
      sat_cnt   <= '0;
    end else begin
      sat_flags <= (sat_clr ? '0 : sat_flags) | (w_clamp ? w_onehot : '0);
      if (sat_clr) begin
        sat_cnt <= w_clamp ? CNT_W'(1) : '0;
      end else if (w_clamp && (sat_cnt != c_cnt_max)) begin
        sat_cnt <= sat_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ek_sat_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ek_sat_mc
// Function : Self-checking bench for ek_sat_mc: directed scenarios followed by
//            random traffic, compared against an integer reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ek_sat_mc;

  localparam int N      = 18;
  localparam int CH_W   = 2;
  localparam int HI     = 255;
  localparam int LO     = -256;
  localparam int CNTMAX = 15;

  logic clk;
  logic reset, in_valid, hist_clr, sat_clr;
  logic [CH_W-1:0] in_ch;
  logic signed [N-1:0] refk, yk;

  logic out_valid, sat_now;
  logic [CH_W-1:0] out_ch;
  logic signed [N-1:0] ek, ek1, ek2, dek;
  logic [3:0] sat_flags;
  logic [3:0] sat_cnt;

  logic out_valid3, sat_now3;
  logic [CH_W-1:0] out_ch3;
  logic signed [N-1:0] ek_3, ek1_3, ek2_3, dek_3;
  logic [2:0] sat_flags3;
  logic [3:0] sat_cnt3;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_h1[4], m_h2[4];
  int m_ek, m_ek1, m_ek2, m_dek, m_ch, m_cnt;
  bit m_ov, m_sn, m_ov3;
  bit [3:0] m_flags;
  bit p_v, p3_v;
  int p_ch, p_diff;

  ek_sat_mc #(.N(N), .LIM_W(9), .CH(4), .CH_W(CH_W), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch),
    .refk(refk), .yk(yk), .hist_clr(hist_clr), .sat_clr(sat_clr),
    .out_valid(out_valid), .out_ch(out_ch), .ek(ek), .ek1(ek1), .ek2(ek2),
    .dek(dek), .sat_now(sat_now), .sat_flags(sat_flags), .sat_cnt(sat_cnt)
  );

  ek_sat_mc #(.N(N), .LIM_W(9), .CH(3), .CH_W(CH_W), .CNT_W(4)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch),
    .refk(refk), .yk(yk), .hist_clr(hist_clr), .sat_clr(sat_clr),
    .out_valid(out_valid3), .out_ch(out_ch3), .ek(ek_3), .ek1(ek1_3), .ek2(ek2_3),
    .dek(dek_3), .sat_now(sat_now3), .sat_flags(sat_flags3), .sat_cnt(sat_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge, from the rules for ek/history/flags.
  task automatic model_edge(input bit v, input int ch, input int d,
                            input bit hc, input bit sc, input bit rst);
    bit clamp;
    int e;
    clamp = 1'b0;
    if (rst) begin
      foreach (m_h1[i]) begin m_h1[i] = 0; m_h2[i] = 0; end
      m_ek = 0; m_ek1 = 0; m_ek2 = 0; m_dek = 0; m_ch = 0; m_cnt = 0;
      m_ov = 0; m_sn = 0; m_ov3 = 0; m_flags = '0;
      p_v = 0; p3_v = 0; p_ch = 0; p_diff = 0;
      return;
    end
    if (p_v) begin
      e = (p_diff > HI) ? HI : (p_diff < LO) ? LO : p_diff;
      clamp = (e != p_diff);
      m_ek = e; m_ek1 = m_h1[p_ch]; m_ek2 = m_h2[p_ch];
      m_dek = e - m_ek1; m_ch = p_ch; m_sn = clamp; m_ov = 1;
      if (!hc) begin m_h2[p_ch] = m_h1[p_ch]; m_h1[p_ch] = e; end
    end else begin
      m_ov = 0; m_sn = 0;
    end
    if (sc) begin m_flags = '0; m_cnt = 0; end
    if (clamp) begin
      m_flags[p_ch] = 1'b1;
      m_cnt = (m_cnt < CNTMAX) ? m_cnt + 1 : CNTMAX;
    end
    if (hc) foreach (m_h1[i]) begin m_h1[i] = 0; m_h2[i] = 0; end
    m_ov3 = p3_v;
    p_v = v && (ch < 4); p3_v = v && (ch < 3);
    p_ch = ch; p_diff = d;
  endtask

  // One clock: drive at negedge, update model at posedge, check #1 later.
  task automatic step(input bit v, input int ch, input int r, input int y,
                      input bit hc, input bit sc, input bit rst);
    logic signed [N-1:0] tr, ty;
    int rs, ys;
    tr = r[N-1:0]; ty = y[N-1:0];
    rs = tr; ys = ty;
    @(negedge clk);
    in_valid = v; in_ch = ch[CH_W-1:0]; refk = tr; yk = ty;
    hist_clr = hc; sat_clr = sc; reset = rst;
    @(posedge clk);
    model_edge(v, ch, rs - ys, hc, sc, rst);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_ch", out_ch, m_ch);
    chk("ek", ek, m_ek);
    chk("ek1", ek1, m_ek1);
    chk("ek2", ek2, m_ek2);
    chk("dek", dek, m_dek);
    if (m_ov) chk("sat_now", sat_now, m_sn);
    chk("sat_flags", sat_flags, m_flags);
    chk("sat_cnt", sat_cnt, m_cnt);
    chk("out_valid_ch3", out_valid3, m_ov3);
  endtask

  task automatic snd(input int ch, input int r, input int y);
    step(1'b1, ch, r, y, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit hc, input bit sc);
    step(1'b0, 0, 0, 0, hc, sc, 1'b0);
  endtask

  initial begin
    in_valid = 0; in_ch = '0; refk = '0; yk = '0;
    hist_clr = 0; sat_clr = 0; reset = 1;

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rst_flags", sat_flags, 0);

    // basic error, two-cycle latency
    snd(0, 100, 30);
    idle(0, 0);
    chk("tp1_valid", out_valid, 1);
    chk("tp1_ek", ek, 70);
    chk("tp1_dek", dek, 70);

    // clamp both directions on ch1
    snd(1, 1000, 0);
    snd(1, -1000, 0);
    chk("tp2_ek", ek, 255);
    chk("tp2_flags", sat_flags, 4'b0010);
    chk("tp2_cnt", sat_cnt, 1);
    idle(0, 0);
    chk("tp2b_ek", ek, -256);
    chk("tp2b_ek1", ek1, 255);
    chk("tp2b_dek", dek, -511);
    chk("tp2b_cnt", sat_cnt, 2);

    // full-scale opposite signs
    snd(1, 131071, -131072);
    idle(0, 0);
    chk("tp3_ek", ek, 255);
    chk("tp3_sat", sat_now, 1);

    // interleaved channels
    snd(0, 5, 0);
    snd(2, 7, 0);
    snd(0, 9, 0);
    chk("tp4_ch2_ek1", ek1, 0);
    snd(0, 11, 0);
    idle(0, 0);
    chk("tp4_ek", ek, 11);
    chk("tp4_ek1", ek1, 9);
    chk("tp4_ek2", ek2, 5);

    // hist_clr coincident with a stage-2 sample on ch3
    snd(3, 50, 0);
    snd(3, 20, 0);
    idle(1, 0);
    chk("tp5_old_ek1", ek1, 50);
    snd(3, 4, 0);
    idle(0, 0);
    chk("tp5_ek1", ek1, 0);
    chk("tp5_ek2", ek2, 0);

    // sat_clr coincident with a clamp on ch2
    snd(2, 600, 0);
    idle(0, 1);
    chk("tp6_flags", sat_flags, 4'b0100);
    chk("tp6_cnt", sat_cnt, 1);

    // channel 3 dropped by the CH=3 instance
    snd(3, 1, 0);
    idle(0, 0);
    chk("tp7_ov3", out_valid3, 0);

    // reset with two samples in flight
    snd(0, 40, 0);
    snd(1, 41, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(0, 0);
    chk("tp8_valid", out_valid, 0);
    chk("tp8_ek", ek, 0);

    // counter saturation
    for (int i = 0; i < 20; i++) snd(i % 4, 5000, 0);
    idle(0, 0);
    chk("cnt_sat", sat_cnt, CNTMAX);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int r, y, mode;
      logic signed [N-1:0] t;
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        r = int'($urandom_range(0, 600)) - 300;
        y = int'($urandom_range(0, 600)) - 300;
      end else if (mode == 1) begin
        r = int'($urandom_range(0, 4000)) - 2000;
        y = int'($urandom_range(0, 4000)) - 2000;
      end else begin
        t = N'($urandom); r = t;
        t = N'($urandom); y = t;
      end
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), r, y,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) == 0);
    end
    idle(0, 0);
    idle(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
